magnetron_ctrl_logic: RTL and testbench

- Control logic for the microwave oven cooking core.
- Takes the active-low Start, Stop and Clear pushbuttons, the door-closed sensor and the timer-done flag from the countdown timer.
- Runs a 4-state FSM that decides when the magnetron is energised.
- Also drives timer enable/clear and a completion pulse to the timer and display blocks.

---
 rtl/magnetron_ctrl_pkg.sv | 65 ++++++
 rtl/magnetron_ctrl_logic_sync_bit.sv | 25 ++
 rtl/magnetron_ctrl_logic.sv | 87 ++++++++
 tb/tb_magnetron_ctrl_logic.sv | 117 +++++++++++
 4 files changed

// File: rtl/magnetron_ctrl_pkg.sv
// Shared types and constants for the magnetron cooking-core controller.
// Build option: define SYNC_EN to add input synchronizers in front of the FSM.
package magnetron_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COOK  = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int SYNC_STAGES_DEFAULT = 2;

   // Priority clr > open/stop > timer_done > start; a door-open start never enters COOK.
   function automatic state_t next_state(
      input state_t cur,
      input logic   clr,
      input logic   open,
      input logic   stop,
      input logic   tdone,
      input logic   start
   );
      state_t nxt;
      nxt = cur;
      if (clr) begin
         nxt = IDLE;
      end else begin
         case (cur)
            IDLE: begin
               if (start && !open && !tdone && !stop) begin
                  nxt = COOK;
               end else begin
                  nxt = IDLE;
               end
            end
            COOK: begin
               if (open || stop) begin
                  nxt = PAUSE;
               end else if (tdone) begin
                  nxt = DONE;
               end else begin
                  nxt = COOK;
               end
            end
            PAUSE: begin
               if (start && !open && !stop && !tdone) begin
                  nxt = COOK;
               end else begin
                  nxt = PAUSE;
               end
            end
            DONE: begin
               if (open) begin
                  nxt = IDLE;
               end else begin
                  nxt = DONE;
               end
            end
            default: nxt = IDLE;
         endcase
      end
      return nxt;
   endfunction

endpackage

// File: rtl/magnetron_ctrl_logic_sync_bit.sv
// N-stage single-bit flop synchronizer; flops reset to a chosen inactive level.
module sync_bit #(
   parameter int   N         = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [N-1:0] ff;

   // Shift the asynchronous input through the chain.
   always_ff @(posedge clk) begin
      if (rst) begin
         ff <= {N{RESET_VAL}};
      end else begin
         ff <= {ff[N-2:0], d};
      end
   end

   assign q = ff[N-1];

endmodule

// File: rtl/magnetron_ctrl_logic.sv
// Microwave cooking-core control FSM: decides when the magnetron is energised.
// Build option: SYNC_EN inserts SYNC_STAGES-deep synchronizers on all inputs but rst.
module magnetron_ctrl_logic
   import magnetron_ctrl_pkg::*;
#(
   parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       timer_done,
   input  logic       door_closed,
   input  logic       clearn,
   input  logic       startn,
   input  logic       stopn,
   output logic       mag_on,
   output logic       timer_en,
   output logic       timer_clr,
   output logic       done_pulse,
   output logic [1:0] state
);

   logic   td_in;
   logic   dc_in;
   logic   clearn_in;
   logic   startn_in;
   logic   stopn_in;
   logic   clr;
   logic   open;
   logic   stop;
   logic   start;
   state_t cur;
   state_t nxt;

   if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
      $error("SYNC_STAGES must be in 2..4");
   end

`ifdef SYNC_EN
   sync_bit #(.N(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_td (
      .clk(clk), .rst(rst), .d(timer_done),  .q(td_in)
   );
   sync_bit #(.N(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_dc (
      .clk(clk), .rst(rst), .d(door_closed), .q(dc_in)
   );
   sync_bit #(.N(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_clearn (
      .clk(clk), .rst(rst), .d(clearn),      .q(clearn_in)
   );
   sync_bit #(.N(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_startn (
      .clk(clk), .rst(rst), .d(startn),      .q(startn_in)
   );
   sync_bit #(.N(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_stopn (
      .clk(clk), .rst(rst), .d(stopn),       .q(stopn_in)
   );
`else
   assign td_in     = timer_done;
   assign dc_in     = door_closed;
   assign clearn_in = clearn;
   assign startn_in = startn;
   assign stopn_in  = stopn;
`endif

   assign clr   = ~clearn_in;
   assign open  = ~dc_in;
   assign stop  = ~stopn_in;
   assign start = ~startn_in;
   assign nxt   = next_state(cur, clr, open, stop, td_in, start);

   // State register plus registered outputs aligned with each state change.
   always_ff @(posedge clk) begin
      if (rst) begin
         cur        <= IDLE;
         mag_on     <= 1'b0;
         timer_en   <= 1'b0;
         timer_clr  <= 1'b0;
         done_pulse <= 1'b0;
      end else begin
         cur        <= nxt;
         mag_on     <= (nxt == COOK);
         timer_en   <= (nxt == COOK);
         timer_clr  <= clr;
         done_pulse <= (cur == COOK) && (nxt == DONE);
      end
   end

   assign state = cur;

endmodule

// File: tb/tb_magnetron_ctrl_logic.sv
// Randomised and directed bench for magnetron_ctrl_logic against a behavioural model.
module tb_magnetron_ctrl_logic;

   localparam int S_IDLE  = 0;
   localparam int S_COOK  = 1;
   localparam int S_PAUSE = 2;
   localparam int S_DONE  = 3;
`ifdef SYNC_EN
   localparam int LAT = magnetron_ctrl_pkg::SYNC_STAGES_DEFAULT;
`else
   localparam int LAT = 0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       timer_done = 1'b0;
   logic       door_closed = 1'b1;
   logic       clearn = 1'b1;
   logic       startn = 1'b1;
   logic       stopn = 1'b1;
   logic       mag_on;
   logic       timer_en;
   logic       timer_clr;
   logic       done_pulse;
   logic [1:0] state;

   int vectors = 0;
   int miscompares = 0;
   int m_state = S_IDLE;
   // input history {timer_done, door_closed, clearn, startn, stopn}
   logic [4:0] pipe [0:3];

   always #5 clk = ~clk;

   magnetron_ctrl_logic dut (
      .clk(clk), .rst(rst), .timer_done(timer_done), .door_closed(door_closed),
      .clearn(clearn), .startn(startn), .stopn(stopn), .mag_on(mag_on),
      .timer_en(timer_en), .timer_clr(timer_clr), .done_pulse(done_pulse),
      .state(state)
   );

   task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s at %0t: observed %0d expected %0d", tag, $time, obs, exp);
      end
   endtask

   task automatic step(input logic r, input logic t, input logic d,
                       input logic c, input logic s, input logic p);
      logic [4:0] in_v;
      logic [4:0] eff;
      logic       clr, open, stop, start, td;
      int         prev, nxt;
      @(negedge clk);
      rst = r; timer_done = t; door_closed = d; clearn = c; startn = s; stopn = p;
      @(posedge clk);
      #1;
      in_v = {t, d, c, s, p};
      if (LAT == 0) eff = in_v;
      else          eff = pipe[LAT-1];
      for (int i = 3; i > 0; i--) pipe[i] = r ? 5'b01111 : pipe[i-1];
      pipe[0] = r ? 5'b01111 : in_v;
      td = eff[4]; open = !eff[3]; clr = !eff[2]; start = !eff[1]; stop = !eff[0];
      prev = m_state;
      nxt  = m_state;
      if (r)        nxt = S_IDLE;
      else if (clr) nxt = S_IDLE;
      else if (m_state == S_IDLE  && start && !open && !td && !stop) nxt = S_COOK;
      else if (m_state == S_COOK  && (open || stop)) nxt = S_PAUSE;
      else if (m_state == S_COOK  && td) nxt = S_DONE;
      else if (m_state == S_PAUSE && start && !open && !stop && !td) nxt = S_COOK;
      else if (m_state == S_DONE  && open) nxt = S_IDLE;
      m_state = nxt;
      chk("state",      state,              2'(m_state));
      chk("mag_on",     {1'b0, mag_on},     {1'b0, m_state == S_COOK});
      chk("timer_en",   {1'b0, timer_en},   {1'b0, m_state == S_COOK});
      chk("timer_clr",  {1'b0, timer_clr},  {1'b0, !r && clr});
      chk("done_pulse", {1'b0, done_pulse}, {1'b0, !r && prev == S_COOK && nxt == S_DONE});
   endtask

   initial begin
      for (int i = 0; i < 4; i++) pipe[i] = 5'b01111;
      // reset held with start pressed, then cooking starts once released
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      // completion, hold, then door open back to idle
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      // pause, door-open start ignored, then resume
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      // door interlock during cook
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      // clear with start
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      // stop together with timer_done while cooking
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      // reset mid-cook
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 2000; i++) begin
         step($urandom_range(99) < 2, $urandom_range(99) < 10, $urandom_range(99) < 90,
              $urandom_range(99) >= 5, $urandom_range(99) >= 30, $urandom_range(99) >= 10);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
